div_16bit: RTL and testbench

Sequential 16-bit unsigned restoring divider for the basic CPU datapath. It performs the inverse operation of the datapath's add/multiply path by repeated shift-and-subtract, one quotient bit per clock. The ALU issues operands with a start strobe; the divider raises a one-cycle done pulse with the quotient and remainder. It sits beside the combinational adder-subtractor as a multi-cycle execution unit.

---
 rtl/div_16bit_pkg.sv | 12 +
 rtl/trialSub_17bit.sv | 17 +
 rtl/div_16bit.sv | 131 +++++++++++++
 tb/tb_div_16bit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_16bit_pkg.sv
// Shared definitions for the 16-bit restoring divider: default width and FSM states.
package div_16bit_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/trialSub_17bit.sv
// Trial subtraction for one restoring-division step; borrow is the difference MSB.
module trialSub_17bit #(
  parameter int unsigned WIDTH = 17
) (
  input  logic [WIDTH-1:0] iMinuend,
  input  logic [WIDTH-1:0] iSubtrahend,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow
);

  // Difference and sign of the trial result
  always_comb begin
    oDiff   = iMinuend - iSubtrahend;
    oBorrow = oDiff[WIDTH-1];
  end

endmodule

// File: rtl/div_16bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module div_16bit
  import div_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivZero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [2*WIDTH:0] rq_shift;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   r_new;
  logic [WIDTH-1:0] q_new;

  trialSub_17bit #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .iMinuend    (r_shift),
    .iSubtrahend ({1'b0, d_q}),
    .oDiff       (trial_diff),
    .oBorrow     (trial_borrow)
  );

  // Shift {R,Q} left and restore R when the trial subtraction goes negative
  always_comb begin
    rq_shift = {r_q, q_q} << 1;
    r_shift  = rq_shift[2*WIDTH:WIDTH];
    r_new    = trial_borrow ? r_shift : trial_diff;
    q_new    = {rq_shift[WIDTH-1:1], ~trial_borrow};
  end

  // Next-state, datapath loads and result capture
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (iStart) begin
          q_d   = iDividend;
          d_d   = iDivisor;
          r_d   = '0;
          cnt_d = '0;
          if (iDivisor == '0) begin
            state_d = DIV_DONE;
            quo_d   = '1;
            rem_d   = iDividend;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV_CALC;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        r_d   = r_new;
        q_d   = q_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DIV_DONE;
          quo_d   = q_new;
          rem_d   = r_new[WIDTH-1:0];
          dz_d    = 1'b0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= DIV_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Status and result outputs
  always_comb begin
    oBusy      = (state_q == DIV_CALC);
    oDone      = (state_q == DIV_DONE);
    oQuotient  = quo_q;
    oRemainder = rem_q;
    oDivZero   = dz_q;
  end

endmodule

// File: tb/tb_div_16bit.sv
// Self-checking bench for div_16bit: vector table, random ops vs. arithmetic model, corner sequences.
module tb_div_16bit;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic [15:0] iDividend;
  logic [15:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oQuotient;
  logic [15:0] oRemainder;
  logic        oDivZero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  div_16bit #(.WIDTH(16)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivZero   (oDivZero)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for one cycle so they are sampled on the following rising edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge iClk);
    iStart    = 1'b1;
    iDividend = a;
    iDivisor  = b;
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    iDividend = 16'($urandom);
    iDivisor  = 16'($urandom);
  endtask

  // Count falling edges until oDone; lat=0 means it never came
  task automatic wait_done(output int lat, output int busy_n, output logic busy_at_done);
    lat = 0;
    busy_n = 0;
    busy_at_done = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge iClk);
      if (oDone) begin
        lat = k;
        busy_at_done = oBusy;
        break;
      end
      if (oBusy) busy_n++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz);
    int   lat, busy_n;
    logic bad;
    start_op(a, b);
    wait_done(lat, busy_n, bad);
    check({name, " latency"}, lat, edz ? 1 : 17);
    check({name, " busy cycles"}, busy_n, edz ? 0 : 16);
    check({name, " busy at done"}, {31'd0, bad}, 0);
    check({name, " quotient"}, {16'd0, oQuotient}, {16'd0, eq});
    check({name, " remainder"}, {16'd0, oRemainder}, {16'd0, er});
    check({name, " divzero"}, {31'd0, oDivZero}, {31'd0, edz});
    @(negedge iClk);
    check({name, " done one cycle"}, {31'd0, oDone}, 0);
    check({name, " quotient held"}, {16'd0, oQuotient}, {16'd0, eq});
  endtask

  vec_t vecs[6];

  initial begin
    int   lat, busy_n, dones;
    logic bad;
    logic [15:0] a, b, mq, mr;

    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,   1'b0};
    vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0};
    vecs[2] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0};
    vecs[3] = '{16'd3,     16'd10,    16'd0,     16'd3,   1'b0};
    vecs[4] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,   1'b1};
    vecs[5] = '{16'd0,     16'd3,     16'd0,     16'd0,   1'b0};

    iRst_n = 1'b0;
    iStart = 1'b0;
    iDividend = '0;
    iDivisor = '0;
    #2;
    check("reset busy", {31'd0, oBusy}, 0);
    check("reset done", {31'd0, oDone}, 0);
    check("reset quotient", {16'd0, oQuotient}, 0);
    check("reset remainder", {16'd0, oRemainder}, 0);
    check("reset divzero", {31'd0, oDivZero}, 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (b == 0) begin
        mq = 16'hFFFF;
        mr = a;
      end else begin
        mq = a / b;
        mr = a % b;
      end
      run_op($sformatf("rand%0d", i), a, b, mq, mr, b == 0);
    end

    // Start pulse mid-calculation is ignored
    start_op(16'd100, 16'd7);
    repeat (5) @(negedge iClk);
    iStart = 1'b1;
    iDividend = 16'd9;
    iDivisor = 16'd2;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    wait_done(lat, busy_n, bad);
    check("ignore latency", lat, 12);
    check("ignore quotient", {16'd0, oQuotient}, 14);
    check("ignore remainder", {16'd0, oRemainder}, 2);

    // Back-to-back: new start accepted in the done cycle
    @(negedge iClk);
    start_op(16'd100, 16'd7);
    wait_done(lat, busy_n, bad);
    check("b2b first latency", lat, 17);
    iStart = 1'b1;
    iDividend = 16'd9;
    iDivisor = 16'd2;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    @(negedge iClk);
    check("b2b done drops", {31'd0, oDone}, 0);
    check("b2b busy", {31'd0, oBusy}, 1);
    check("b2b quotient held", {16'd0, oQuotient}, 14);
    check("b2b remainder held", {16'd0, oRemainder}, 2);
    wait_done(lat, busy_n, bad);
    check("b2b second latency", lat, 16);
    check("b2b quotient", {16'd0, oQuotient}, 4);
    check("b2b remainder", {16'd0, oRemainder}, 1);

    // Asynchronous reset mid-calculation
    @(negedge iClk);
    start_op(16'd100, 16'd7);
    repeat (8) @(negedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    check("midrst busy", {31'd0, oBusy}, 0);
    check("midrst done", {31'd0, oDone}, 0);
    check("midrst quotient", {16'd0, oQuotient}, 0);
    check("midrst remainder", {16'd0, oRemainder}, 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge iClk);
      if (oDone) dones++;
    end
    check("midrst no done", dones, 0);
    run_op("after reset", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
